// File: rtl/execute_stage_if.sv
// Execute-stage bus: ID/EX inputs, forwarding selects, branch redirect and EX/MEM outputs.
// Latency: n/a (signal bundle only).
// Backpressure: none; the pipeline advances every cycle.
interface execute_stage_if;
  // Control from ID/EX
  logic        RegWriteE;
  logic        MemWriteE;
  logic        JumpE;
  logic        BranchE;
  logic        ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  // Operands and PC values from ID/EX
  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [31:0] PCE;
  logic [31:0] ImmExtE;
  logic [31:0] PCPlus4E;
  logic [4:0]  RDE;
  // Forwarding
  logic [1:0]  ForwardAE;
  logic [1:0]  ForwardBE;
  logic [31:0] ResultW;
  // Redirect toward fetch / hazard unit
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  // EX/MEM register toward memory stage
  logic        RegWriteM;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] PCPlus4M;
  logic [4:0]  RDM;

  // Pipeline side that feeds the execute stage and consumes its results
  modport master (
    output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
    output RD1E, RD2E, PCE, ImmExtE, PCPlus4E, RDE,
    output ForwardAE, ForwardBE, ResultW,
    input  PCSrcE, PCTargetE,
    input  RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, PCPlus4M, RDM
  );

  // The execute stage itself
  modport slave (
    input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
    input  RD1E, RD2E, PCE, ImmExtE, PCPlus4E, RDE,
    input  ForwardAE, ForwardBE, ResultW,
    output PCSrcE, PCTargetE,
    output RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, PCPlus4M, RDM
  );
endinterface

// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution, EX/MEM register.
// Latency: PCSrcE/PCTargetE combinational; M outputs 1 cycle after E inputs.
// Backpressure: none; the EX/MEM register captures every cycle (no stall or flush).
module execute_stage (
  input  logic           clk,
  input  logic           rst,
  execute_stage_if.slave ex
);

  logic [31:0] src_a;
  logic [31:0] write_data_e;
  logic [31:0] src_b;
  logic [31:0] alu_result_e;
  logic        zero_e;

  // EX/MEM register contents; alu_result_m also serves as the M-stage forward source
  logic        reg_write_m;
  logic        mem_write_m;
  logic [1:0]  result_src_m;
  logic [31:0] alu_result_m;
  logic [31:0] write_data_m;
  logic [31:0] pc_plus4_m;
  logic [4:0]  rd_m;

  // Operand A forwarding: M forward reads the value held before this edge's update
  always_comb begin
    src_a = ex.RD1E;
    case (ex.ForwardAE)
      2'b01:   src_a = ex.ResultW;
      2'b10:   src_a = alu_result_m;
      default: src_a = ex.RD1E;
    endcase
  end

  // Operand B forwarding; the forwarded value is also the store data
  always_comb begin
    write_data_e = ex.RD2E;
    case (ex.ForwardBE)
      2'b01:   write_data_e = ex.ResultW;
      2'b10:   write_data_e = alu_result_m;
      default: write_data_e = ex.RD2E;
    endcase
  end

  assign src_b = ex.ALUSrcE ? ex.ImmExtE : write_data_e;

  // ALU: 32-bit wrapping results, no overflow flag
  always_comb begin
    alu_result_e = 32'd0;
    case (ex.ALUControlE)
      3'b000:  alu_result_e = src_a + src_b;
      3'b001:  alu_result_e = src_a - src_b;
      3'b010:  alu_result_e = src_a & src_b;
      3'b011:  alu_result_e = src_a | src_b;
      3'b100:  alu_result_e = src_a ^ src_b;
      3'b101:  alu_result_e = {31'd0, $signed(src_a) < $signed(src_b)};
      3'b110:  alu_result_e = src_a << src_b[4:0];
      3'b111:  alu_result_e = src_a >> src_b[4:0];
      default: alu_result_e = 32'd0;
    endcase
  end

  assign zero_e = (alu_result_e == 32'd0);

  // Branch target uses its own adder so it never waits on the ALU result
  assign ex.PCTargetE = ex.PCE + ex.ImmExtE;

  // Redirect is suppressed during reset so fetch does not jump while the pipe is cleared
  assign ex.PCSrcE = ~rst & ((ex.BranchE & zero_e) | ex.JumpE);

  // EX/MEM register: reset wins over capture of the in-flight instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= 2'b00;
      alu_result_m <= 32'd0;
      write_data_m <= 32'd0;
      pc_plus4_m   <= 32'd0;
      rd_m         <= 5'd0;
    end else begin
      reg_write_m  <= ex.RegWriteE;
      mem_write_m  <= ex.MemWriteE;
      result_src_m <= ex.ResultSrcE;
      alu_result_m <= alu_result_e;
      write_data_m <= write_data_e;
      pc_plus4_m   <= ex.PCPlus4E;
      rd_m         <= ex.RDE;
    end
  end

  assign ex.RegWriteM  = reg_write_m;
  assign ex.MemWriteM  = mem_write_m;
  assign ex.ResultSrcM = result_src_m;
  assign ex.ALUResultM = alu_result_m;
  assign ex.WriteDataM = write_data_m;
  assign ex.PCPlus4M   = pc_plus4_m;
  assign ex.RDM        = rd_m;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed plan cases plus randomized traffic.
// Latency: checks comb outputs before each edge and M outputs 1 ns after it.
// Backpressure: none; one instruction is applied per clock.
module tb_execute_stage;

  logic clk;
  logic rst;

  execute_stage_if ex_if ();

  execute_stage dut (
    .clk (clk),
    .rst (rst),
    .ex  (ex_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference EX/MEM contents as the memory stage should see them
  logic        m_regwrite;
  logic        m_memwrite;
  logic [1:0]  m_resultsrc;
  logic [31:0] m_alu;
  logic [31:0] m_wd;
  logic [31:0] m_pc4;
  logic [4:0]  m_rd;

  logic [31:0] sweep_exp [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      3'd6: return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_val,
                                       input logic [31:0] wb_val, input logic [31:0] mem_val);
    if (sel == 2'b01) return wb_val;
    if (sel == 2'b10) return mem_val;
    return reg_val;
  endfunction

  // Apply current inputs for one cycle: check redirect now, EX/MEM after the edge
  task automatic step(input string tag);
    logic [31:0] a, wd, b, res, tgt;
    logic        taken;
    a     = pick(ex_if.ForwardAE, ex_if.RD1E, ex_if.ResultW, m_alu);
    wd    = pick(ex_if.ForwardBE, ex_if.RD2E, ex_if.ResultW, m_alu);
    b     = ex_if.ALUSrcE ? ex_if.ImmExtE : wd;
    res   = ref_alu(ex_if.ALUControlE, a, b);
    tgt   = ex_if.PCE + ex_if.ImmExtE;
    taken = !rst && ((ex_if.BranchE && res == 32'd0) || ex_if.JumpE);
    #1;
    check({tag, ".pcsrc"},  {31'd0, ex_if.PCSrcE}, {31'd0, taken});
    check({tag, ".target"}, ex_if.PCTargetE, tgt);
    if (rst) begin
      m_regwrite = 0; m_memwrite = 0; m_resultsrc = 0;
      m_alu = 0; m_wd = 0; m_pc4 = 0; m_rd = 0;
    end else begin
      m_regwrite = ex_if.RegWriteE; m_memwrite = ex_if.MemWriteE;
      m_resultsrc = ex_if.ResultSrcE; m_alu = res; m_wd = wd;
      m_pc4 = ex_if.PCPlus4E; m_rd = ex_if.RDE;
    end
    @(posedge clk);
    #1;
    check({tag, ".regwrite"},  {31'd0, ex_if.RegWriteM}, {31'd0, m_regwrite});
    check({tag, ".memwrite"},  {31'd0, ex_if.MemWriteM}, {31'd0, m_memwrite});
    check({tag, ".resultsrc"}, {30'd0, ex_if.ResultSrcM}, {30'd0, m_resultsrc});
    check({tag, ".alu"},       ex_if.ALUResultM, m_alu);
    check({tag, ".wdata"},     ex_if.WriteDataM, m_wd);
    check({tag, ".pc4"},       ex_if.PCPlus4M, m_pc4);
    check({tag, ".rd"},        {27'd0, ex_if.RDM}, {27'd0, m_rd});
  endtask

  task automatic randomize_inputs();
    ex_if.RegWriteE   = 1'($urandom);
    ex_if.MemWriteE   = 1'($urandom);
    ex_if.JumpE       = ($urandom_range(0, 5) == 0);
    ex_if.BranchE     = 1'($urandom);
    ex_if.ALUSrcE     = 1'($urandom);
    ex_if.ResultSrcE  = 2'($urandom);
    ex_if.ALUControlE = 3'($urandom);
    ex_if.RD1E        = $urandom;
    ex_if.RD2E        = ($urandom_range(0, 3) == 0) ? ex_if.RD1E : $urandom;
    ex_if.PCE         = $urandom;
    ex_if.ImmExtE     = $urandom;
    ex_if.PCPlus4E    = $urandom;
    ex_if.RDE         = 5'($urandom);
    ex_if.ForwardAE   = 2'($urandom);
    ex_if.ForwardBE   = 2'($urandom);
    ex_if.ResultW     = $urandom;
  endtask

  task automatic clear_inputs();
    ex_if.RegWriteE = 0; ex_if.MemWriteE = 0; ex_if.JumpE = 0; ex_if.BranchE = 0;
    ex_if.ALUSrcE = 0; ex_if.ResultSrcE = 0; ex_if.ALUControlE = 0;
    ex_if.RD1E = 0; ex_if.RD2E = 0; ex_if.PCE = 0; ex_if.ImmExtE = 0;
    ex_if.PCPlus4E = 0; ex_if.RDE = 0; ex_if.ForwardAE = 0; ex_if.ForwardBE = 0;
    ex_if.ResultW = 0;
  endtask

  initial begin
    sweep_exp[0] = 32'h0000_0000; sweep_exp[1] = 32'hFFFF_FFFE;
    sweep_exp[2] = 32'h0000_0001; sweep_exp[3] = 32'hFFFF_FFFF;
    sweep_exp[4] = 32'hFFFF_FFFE; sweep_exp[5] = 32'h0000_0001;
    sweep_exp[6] = 32'hFFFF_FFFE; sweep_exp[7] = 32'h7FFF_FFFF;
    m_regwrite = 0; m_memwrite = 0; m_resultsrc = 0;
    m_alu = 0; m_wd = 0; m_pc4 = 0; m_rd = 0;

    // Reset held two cycles with busy, nonzero inputs (jump forces a would-be redirect)
    rst = 1'b1;
    randomize_inputs();
    ex_if.JumpE = 1'b1; ex_if.RegWriteE = 1'b1; ex_if.MemWriteE = 1'b1;
    @(negedge clk);
    step("reset0");
    step("reset1");
    check("reset.alu_zero", ex_if.ALUResultM, 32'd0);
    rst = 1'b0;

    // First instruction after release lands on M after one edge
    clear_inputs();
    ex_if.RegWriteE = 1; ex_if.RDE = 5'd3; ex_if.RD1E = 32'd10; ex_if.RD2E = 32'd4;
    ex_if.PCPlus4E = 32'h0000_0014;
    step("first");
    check("first.alu", ex_if.ALUResultM, 32'd14);

    // ALU sweep against fixed expected values
    for (int op = 0; op < 8; op++) begin
      clear_inputs();
      ex_if.RD1E = 32'hFFFF_FFFF; ex_if.RD2E = 32'd1; ex_if.ALUControlE = 3'(op);
      step("sweep");
      check($sformatf("sweep_op%0d", op), ex_if.ALUResultM, sweep_exp[op]);
    end

    // Forwarding chain: addi x1 = 5, then forward from M, then forward store data from W
    clear_inputs();
    ex_if.RegWriteE = 1; ex_if.ALUSrcE = 1; ex_if.RD1E = 32'd2; ex_if.ImmExtE = 32'd3;
    ex_if.RDE = 5'd1;
    step("addi");
    check("fwd.addi", ex_if.ALUResultM, 32'd5);
    ex_if.ForwardAE = 2'b10; ex_if.RD1E = 32'd0; ex_if.ImmExtE = 32'd3; ex_if.RDE = 5'd2;
    step("fwd_m");
    check("fwd.m_add", ex_if.ALUResultM, 32'd8);
    ex_if.ForwardAE = 2'b00; ex_if.RegWriteE = 0; ex_if.MemWriteE = 1;
    ex_if.ForwardBE = 2'b01; ex_if.ResultW = 32'd7; ex_if.RD2E = 32'd99;
    step("fwd_w");
    check("fwd.w_store", ex_if.WriteDataM, 32'd7);

    // Branch taken and not taken
    clear_inputs();
    ex_if.BranchE = 1; ex_if.RD1E = 32'd9; ex_if.RD2E = 32'd9; ex_if.ALUControlE = 3'b001;
    ex_if.PCE = 32'h100; ex_if.ImmExtE = 32'hFFFF_FFF0;
    #1;
    check("beq.taken", {31'd0, ex_if.PCSrcE}, 32'd1);
    check("beq.target", ex_if.PCTargetE, 32'h0000_00F0);
    step("beq_t");
    ex_if.RD2E = 32'd8;
    #1;
    check("beq.not_taken", {31'd0, ex_if.PCSrcE}, 32'd0);
    step("beq_n");

    // Jump and link
    clear_inputs();
    ex_if.JumpE = 1; ex_if.PCE = 32'h200; ex_if.ImmExtE = 32'h40; ex_if.PCPlus4E = 32'h204;
    ex_if.RegWriteE = 1; ex_if.RDE = 5'd1; ex_if.ResultSrcE = 2'b10;
    #1;
    check("jal.pcsrc", {31'd0, ex_if.PCSrcE}, 32'd1);
    check("jal.target", ex_if.PCTargetE, 32'h240);
    step("jal");
    check("jal.pc4", ex_if.PCPlus4M, 32'h204);
    check("jal.rd", {27'd0, ex_if.RDM}, 32'd1);

    // Jump and branch together still redirect to the same target
    ex_if.BranchE = 1; ex_if.RD1E = 32'd1;
    step("jal_br");

    // Bubble after the flush
    clear_inputs();
    step("bubble");
    check("bubble.regwrite", {31'd0, ex_if.RegWriteM}, 32'd0);

    // x0 destination with RegWrite passes through untouched
    ex_if.RegWriteE = 1; ex_if.RDE = 5'd0;
    step("x0");

    // Randomized traffic with occasional mid-stream resets
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      rst = ($urandom_range(0, 19) == 0);
      step("rand");
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
